amos_perf_cnt_bank: RTL and testbench



---
 rtl/amos_perf_cnt_bank_if.sv | 26 ++
 rtl/amos_perf_cnt_bank.sv | 70 +++++++
 tb/tb_amos_perf_cnt_bank.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/amos_perf_cnt_bank_if.sv
// amos_perf_cnt_bank_if: event strobes, controller act/clear vectors and counter values
interface amos_perf_cnt_bank_if #(
   parameter int NUM_CNT   = 32,
   parameter int CNT_WIDTH = 32
);
   logic                 amo_req_valid_i;
   logic                 amo_req_ready_i;
   logic                 amo_rsp_i;
   logic                 col_stall_i;
   logic                 wf_busy_i;
   logic [NUM_CNT-1:0]   amos_perf_cnt_act_i;
   logic [NUM_CNT-1:0]   amos_perf_cnt_rst_ni;
   logic [CNT_WIDTH-1:0] amos_perf_cnt_o [NUM_CNT];

   modport master (
      output amo_req_valid_i, amo_req_ready_i, amo_rsp_i, col_stall_i, wf_busy_i,
      output amos_perf_cnt_act_i, amos_perf_cnt_rst_ni,
      input  amos_perf_cnt_o
   );

   modport slave (
      input  amo_req_valid_i, amo_req_ready_i, amo_rsp_i, col_stall_i, wf_busy_i,
      input  amos_perf_cnt_act_i, amos_perf_cnt_rst_ni,
      output amos_perf_cnt_o
   );
endinterface

// File: rtl/amos_perf_cnt_bank.sv
// amos_perf_cnt_bank: turns AMO adapter event strobes into performance-counter values
module amos_perf_cnt_bank #(
   parameter int NUM_CNT   = 32,
   parameter int CNT_WIDTH = 32,
   parameter int MAX_OUTST = 8,
   parameter bit SATURATE  = 1'b1
) (
   input logic clk_i,
   input logic rst_i,
   amos_perf_cnt_bank_if.slave bus
);
   localparam int OW = $clog2(MAX_OUTST + 1);

   logic [OW-1:0] outst;
   logic          col_q;
   logic          wf_q;
   logic          hs;
   logic          busy;
   logic [8:0]    ev;
   logic          unused_hi;

   assign hs   = bus.amo_req_valid_i & bus.amo_req_ready_i;
   assign busy = outst != '0;
   assign ev   = {1'b1,
                  bus.wf_busy_i,
                  bus.wf_busy_i & ~wf_q,
                  bus.col_stall_i,
                  bus.col_stall_i & ~col_q,
                  bus.amo_req_valid_i & ~bus.amo_req_ready_i & busy,
                  hs & busy,
                  busy,
                  hs};
   assign unused_hi = ^{bus.amos_perf_cnt_act_i[NUM_CNT-1:9], bus.amos_perf_cnt_rst_ni[NUM_CNT-1:9]};

   // Outstanding AMO tracker; simultaneous issue and completion cancel out
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) outst <= '0;
      else if (hs && !bus.amo_rsp_i && outst != OW'(MAX_OUTST)) outst <= outst + OW'(1);
      else if (!hs && bus.amo_rsp_i && outst != '0) outst <= outst - OW'(1);
   end

   // Previous-cycle levels for stall-episode edge detection, independent of act
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) {col_q, wf_q} <= '0;
      else {col_q, wf_q} <= {bus.col_stall_i, bus.wf_busy_i};
   end

   for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
      if (i < 9) begin : g_live
         logic [CNT_WIDTH-1:0] cnt;
         // Clear beats increment; an all-ones counter sticks when saturating
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) cnt <= '0;
            else if (!bus.amos_perf_cnt_rst_ni[i]) cnt <= '0;
            else if (bus.amos_perf_cnt_act_i[i] && ev[i] && !(SATURATE && &cnt)) cnt <= cnt + CNT_WIDTH'(1);
         end
         assign bus.amos_perf_cnt_o[i] = cnt;
      end else begin : g_zero
         assign bus.amos_perf_cnt_o[i] = '0;
      end
   end

   a_rsp_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(bus.amo_rsp_i && !hs && outst == '0))
      else $warning("amo_rsp with no AMO outstanding");

   a_outst_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(hs && !bus.amo_rsp_i && outst == OW'(MAX_OUTST)))
      else $warning("AMO accepted with tracker already full");
endmodule

// File: tb/tb_amos_perf_cnt_bank.sv
// tb_amos_perf_cnt_bank: directed and random stimulus against a behavioural counter model
module tb_amos_perf_cnt_bank;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   amos_perf_cnt_bank_if #(.NUM_CNT(32), .CNT_WIDTH(32)) m_if ();
   amos_perf_cnt_bank_if #(.NUM_CNT(32), .CNT_WIDTH(4))  s_if ();
   amos_perf_cnt_bank_if #(.NUM_CNT(32), .CNT_WIDTH(4))  w_if ();

   assign s_if.amo_req_valid_i      = m_if.amo_req_valid_i;
   assign s_if.amo_req_ready_i      = m_if.amo_req_ready_i;
   assign s_if.amo_rsp_i            = m_if.amo_rsp_i;
   assign s_if.col_stall_i          = m_if.col_stall_i;
   assign s_if.wf_busy_i            = m_if.wf_busy_i;
   assign s_if.amos_perf_cnt_act_i  = m_if.amos_perf_cnt_act_i;
   assign s_if.amos_perf_cnt_rst_ni = m_if.amos_perf_cnt_rst_ni;
   assign w_if.amo_req_valid_i      = m_if.amo_req_valid_i;
   assign w_if.amo_req_ready_i      = m_if.amo_req_ready_i;
   assign w_if.amo_rsp_i            = m_if.amo_rsp_i;
   assign w_if.col_stall_i          = m_if.col_stall_i;
   assign w_if.wf_busy_i            = m_if.wf_busy_i;
   assign w_if.amos_perf_cnt_act_i  = m_if.amos_perf_cnt_act_i;
   assign w_if.amos_perf_cnt_rst_ni = m_if.amos_perf_cnt_rst_ni;

   amos_perf_cnt_bank #(.CNT_WIDTH(32), .SATURATE(1'b1)) dut   (.clk_i(clk), .rst_i(rst), .bus(m_if));
   amos_perf_cnt_bank #(.CNT_WIDTH(4),  .SATURATE(1'b1)) dut_s (.clk_i(clk), .rst_i(rst), .bus(s_if));
   amos_perf_cnt_bank #(.CNT_WIDTH(4),  .SATURATE(1'b0)) dut_w (.clk_i(clk), .rst_i(rst), .bus(w_if));

   int checks = 0;
   int errors = 0;
   int outst;
   bit col_p, wf_p;
   longint m32 [9];
   int ms [9];
   int mw [9];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      outst = 0;
      col_p = 0;
      wf_p  = 0;
      for (int i = 0; i < 9; i++) begin
         m32[i] = 0;
         ms[i]  = 0;
         mw[i]  = 0;
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < 32; i++)
         chk($sformatf("cnt%0d", i), m_if.amos_perf_cnt_o[i], i < 9 ? 32'(m32[i]) : 32'd0);
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("sat%0d", i), 32'(s_if.amos_perf_cnt_o[i]), 32'(ms[i]));
         chk($sformatf("wrap%0d", i), 32'(w_if.amos_perf_cnt_o[i]), 32'(mw[i]));
      end
   endtask

   task automatic drive(input bit v, input bit r, input bit rsp, input bit col, input bit wf);
      m_if.amo_req_valid_i = v;
      m_if.amo_req_ready_i = r;
      m_if.amo_rsp_i       = rsp;
      m_if.col_stall_i     = col;
      m_if.wf_busy_i       = wf;
   endtask

   // advance one clock: derive the cycle's events from the rules, apply them, then compare
   task automatic step();
      bit ev [9];
      bit v, r, rsp, col, wf, hs;
      v   = m_if.amo_req_valid_i;
      r   = m_if.amo_req_ready_i;
      rsp = m_if.amo_rsp_i;
      col = m_if.col_stall_i;
      wf  = m_if.wf_busy_i;
      hs  = v && r;
      ev[0] = hs;
      ev[1] = outst > 0;
      ev[2] = hs && outst > 0;
      ev[3] = v && !r && outst > 0;
      ev[4] = col && !col_p;
      ev[5] = col;
      ev[6] = wf && !wf_p;
      ev[7] = wf;
      ev[8] = 1;
      @(posedge clk);
      for (int i = 0; i < 9; i++) begin
         if (!m_if.amos_perf_cnt_rst_ni[i]) begin
            m32[i] = 0;
            ms[i]  = 0;
            mw[i]  = 0;
         end else if (m_if.amos_perf_cnt_act_i[i] && ev[i]) begin
            m32[i] = m32[i] >= 64'hFFFF_FFFF ? 64'hFFFF_FFFF : m32[i] + 1;
            ms[i]  = ms[i] >= 15 ? 15 : ms[i] + 1;
            mw[i]  = (mw[i] + 1) % 16;
         end
      end
      if (hs && !rsp) outst = outst < 8 ? outst + 1 : 8;
      else if (rsp && !hs) outst = outst > 0 ? outst - 1 : 0;
      col_p = col;
      wf_p  = wf;
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      drive(0, 0, 0, 0, 0);
      for (int k = 0; k < n; k++) step();
   endtask

   // reset is raised between edges so the zeroed outputs also prove it acts asynchronously
   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      #2;
      compare_all();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      drive(0, 0, 0, 0, 0);
      m_if.amos_perf_cnt_act_i  = '1;
      m_if.amos_perf_cnt_rst_ni = '1;
      #1;
      do_reset();

      idle(10);
      chk("ref10", m_if.amos_perf_cnt_o[8], 32'd10);
      chk("amos_idle", m_if.amos_perf_cnt_o[0], 32'd0);
      chk("hi_zero", m_if.amos_perf_cnt_o[31], 32'd0);

      do_reset();
      for (int c = 0; c < 10; c++) begin
         drive(c < 3, c < 3, c >= 5 && c <= 7, 0, 0);
         step();
      end
      chk("num_amos", m_if.amos_perf_cnt_o[0], 32'd3);
      chk("num_b2b", m_if.amos_perf_cnt_o[2], 32'd2);
      chk("cyc_amos", m_if.amos_perf_cnt_o[1], 32'd7);

      do_reset();
      drive(1, 1, 0, 0, 0);
      step();
      drive(1, 1, 1, 0, 0);
      step();
      idle(2);
      chk("same_num", m_if.amos_perf_cnt_o[0], 32'd2);
      chk("same_b2b", m_if.amos_perf_cnt_o[2], 32'd1);
      chk("same_cyc", m_if.amos_perf_cnt_o[1], 32'd3);

      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         for (int c = 0; c < 8; c++) begin
            m_if.amos_perf_cnt_act_i[4] = !(pass == 1 && c < 5);
            drive(0, 0, 0, c < 4 || c == 5 || c == 6, 0);
            step();
         end
         chk("col_num", m_if.amos_perf_cnt_o[4], pass == 0 ? 32'd2 : 32'd1);
         chk("col_cyc", m_if.amos_perf_cnt_o[5], 32'd6);
      end

      do_reset();
      for (int c = 0; c < 6; c++) begin
         drive(0, 0, 0, 0, c >= 1 && c <= 3);
         step();
      end
      chk("wf_num", m_if.amos_perf_cnt_o[6], 32'd1);
      chk("wf_cyc", m_if.amos_perf_cnt_o[7], 32'd3);

      do_reset();
      idle(17);
      chk("sat_top", 32'(s_if.amos_perf_cnt_o[8]), 32'd15);
      chk("wrap_top", 32'(w_if.amos_perf_cnt_o[8]), 32'd1);

      do_reset();
      idle(5);
      m_if.amos_perf_cnt_rst_ni[8] = 1'b0;
      step();
      chk("clr0", m_if.amos_perf_cnt_o[8], 32'd0);
      m_if.amos_perf_cnt_rst_ni[8] = 1'b1;
      step();
      chk("clr1", m_if.amos_perf_cnt_o[8], 32'd1);
      step();
      chk("clr2", m_if.amos_perf_cnt_o[8], 32'd2);

      do_reset();
      drive(1, 1, 0, 0, 0);
      step();
      step();
      do_reset();
      drive(0, 0, 1, 0, 0);
      step();
      idle(3);
      chk("rst_drop", m_if.amos_perf_cnt_o[1], 32'd0);

      do_reset();
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(0, 399) == 0) do_reset();
         drive($urandom_range(0, 1), $urandom_range(0, 1),
               outst > 0 ? $urandom_range(0, 2) == 0 : $urandom_range(0, 49) == 0,
               $urandom_range(0, 3) == 0 ? !m_if.col_stall_i : m_if.col_stall_i,
               $urandom_range(0, 3) == 0 ? !m_if.wf_busy_i : m_if.wf_busy_i);
         m_if.amos_perf_cnt_act_i  = $urandom | $urandom;
         m_if.amos_perf_cnt_rst_ni = ~($urandom & $urandom & $urandom & $urandom);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
